// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding, latency codes and default sizing for the hazard scoreboard
package hazard_pkg;
    localparam int NUM_REGS_DEF = 8;
    localparam int DEPTH_DEF    = 3;
    localparam int NUM_SRC_DEF  = 2;
    localparam int LAT_W_DEF    = 2;
    localparam int LAT_ALU      = 1;
    localparam int LAT_LOAD     = 2;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side handshake between pipeline control and the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = hazard_pkg::NUM_REGS_DEF,
    parameter int DEPTH    = hazard_pkg::DEPTH_DEF,
    parameter int NUM_SRC  = hazard_pkg::NUM_SRC_DEF,
    parameter int LAT_W    = hazard_pkg::LAT_W_DEF
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int SEL_W = $clog2(DEPTH + 1);
    logic                     stall_ext;
    logic [DEPTH-1:0]         flush_mask;
    logic                     dec_valid;
    logic [NUM_SRC-1:0]       dec_src_en;
    logic [NUM_SRC*AW-1:0]    dec_src;
    logic                     dec_dst_en;
    logic [AW-1:0]            dec_dst;
    logic [LAT_W-1:0]         dec_lat;
    logic                     dec_halt;
    logic                     issue;
    logic                     stall_dec;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     halted;
    modport master (
        output stall_ext, flush_mask, dec_valid, dec_src_en, dec_src, dec_dst_en, dec_dst, dec_lat, dec_halt,
        input  issue, stall_dec, fwd_sel, halted
    );
    modport slave (
        input  stall_ext, flush_mask, dec_valid, dec_src_en, dec_src, dec_dst_en, dec_dst, dec_lat, dec_halt,
        output issue, stall_dec, fwd_sel, halted
    );
endinterface

// File: rtl/hz_src_match.sv
// hz_src_match: finds the youngest in-flight writer of one source and whether its result is ready yet
module hz_src_match #(
    parameter int DEPTH = 3,
    parameter int AW    = 3,
    parameter int LAT_W = 2,
    parameter int SEL_W = 2
) (
    input  logic                   en,
    input  logic [AW-1:0]          src,
    input  logic [DEPTH:1]         valid,
    input  logic [DEPTH*AW-1:0]    dst,
    input  logic [DEPTH*LAT_W-1:0] lat,
    output logic                   hit,
    output logic [SEL_W-1:0]       sel,
    output logic                   hazard
);
    // Scan oldest to youngest so the youngest match wins; lat 0 behaves as 1 since k >= 1 always.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (en && valid[k] && dst[(k-1)*AW +: AW] == src) begin
                hit = 1'b1;
                sel = SEL_W'(k);
                hazard = int'(lat[(k-1)*LAT_W +: LAT_W]) > k;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations, derives stall/forward selects and drains the pipe on HALT
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int LAT_W    = LAT_W_DEF
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int SEL_W = $clog2(DEPTH + 1);
    state_t                   state_q, state_d;
    logic [DEPTH:1]           ent_valid, live;
    logic [DEPTH*AW-1:0]      ent_dst;
    logic [DEPTH*LAT_W-1:0]   ent_lat;
    logic [NUM_SRC-1:0]       hit, hz;
    logic                     any_hz, run;
    assign live = ent_valid & ~bus.flush_mask;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hz_src_match #(.DEPTH(DEPTH), .AW(AW), .LAT_W(LAT_W), .SEL_W(SEL_W)) u_match (
            .en     (bus.dec_src_en[i]),
            .src    (bus.dec_src[i*AW +: AW]),
            .valid  (live),
            .dst    (ent_dst),
            .lat    (ent_lat),
            .hit    (hit[i]),
            .sel    (bus.fwd_sel[i*SEL_W +: SEL_W]),
            .hazard (hz[i])
        );
    end
    assign any_hz        = |(hit & hz);
    assign run           = (state_q == RUN) & ~rst;
    assign bus.stall_dec = run & bus.dec_valid & ~bus.stall_ext & any_hz;
    assign bus.issue     = run & bus.dec_valid & ~bus.stall_ext & ~any_hz;
    assign bus.halted    = state_q == HALTED;
    // Enter DRAIN when HALT issues; finish once every tracked entry has gone, unless frozen.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && bus.issue && bus.dec_halt) state_d = DRAIN;
        if (state_q == DRAIN && !bus.stall_ext && live == '0) state_d = HALTED;
    end
    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end
    // Entry pipe: freeze holds contents but still honours flush; otherwise shift, new entry or bubble at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_dst   <= '0;
            ent_lat   <= '0;
        end else if (bus.stall_ext) begin
            ent_valid <= live;
        end else begin
            ent_valid <= {live[DEPTH-1:1], bus.issue & bus.dec_dst_en};
            ent_dst   <= {ent_dst[(DEPTH-1)*AW-1:0], bus.dec_dst};
            ent_lat   <= {ent_lat[(DEPTH-1)*LAT_W-1:0], bus.dec_lat};
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus hand-written freeze/flush/halt/reset sequences
module tb_hazard_scoreboard;
    import hazard_pkg::*;
    localparam int AW    = 3;
    localparam int SEL_W = 2;
    typedef struct {
        logic       v;
        logic [1:0] sen;
        int         s0, s1;
        logic       den;
        int         d, lat;
        int         iss, stl, sel0, sel1;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int passed = 0;
    int total  = 0;
    vec_t vt[16];
    always #5 clk = ~clk;
    hazard_scoreboard_if bus ();
    hazard_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic expect_out(input string tag, input int iss, input int stl, input int s0, input int s1, input int hlt);
        chk({tag, " issue"}, int'(bus.issue), iss);
        chk({tag, " stall_dec"}, int'(bus.stall_dec), stl);
        chk({tag, " fwd_sel0"}, int'(bus.fwd_sel[SEL_W-1:0]), s0);
        chk({tag, " fwd_sel1"}, int'(bus.fwd_sel[2*SEL_W-1:SEL_W]), s1);
        chk({tag, " halted"}, int'(bus.halted), hlt);
    endtask
    task automatic drive(input logic v, input logic [1:0] sen, input int s0, input int s1,
                         input logic den, input int d, input int lat, input logic halt);
        bus.dec_valid  = v;
        bus.dec_src_en = sen;
        bus.dec_src    = {AW'(s1), AW'(s0)};
        bus.dec_dst_en = den;
        bus.dec_dst    = AW'(d);
        bus.dec_lat    = 2'(lat);
        bus.dec_halt   = halt;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        drive(1'b0, 2'b00, 0, 0, 1'b0, 0, 1, 1'b0);
        repeat (n) step();
    endtask
    initial begin
        vt[0]  = '{1'b1, 2'b00, 0, 0, 1'b1, 1, LAT_ALU,  1, 0, 0, 0};
        vt[1]  = '{1'b1, 2'b01, 1, 0, 1'b1, 6, LAT_ALU,  1, 0, 1, 0};
        vt[2]  = '{1'b1, 2'b01, 1, 0, 1'b0, 0, LAT_ALU,  1, 0, 2, 0};
        vt[3]  = '{1'b1, 2'b00, 0, 0, 1'b1, 2, LAT_LOAD, 1, 0, 0, 0};
        vt[4]  = '{1'b1, 2'b10, 0, 2, 1'b0, 0, LAT_ALU,  0, 1, 0, 1};
        vt[5]  = '{1'b1, 2'b10, 0, 2, 1'b0, 0, LAT_ALU,  1, 0, 0, 2};
        vt[6]  = '{1'b1, 2'b00, 0, 0, 1'b1, 3, LAT_ALU,  1, 0, 0, 0};
        vt[7]  = '{1'b1, 2'b00, 0, 0, 1'b1, 3, LAT_ALU,  1, 0, 0, 0};
        vt[8]  = '{1'b1, 2'b11, 3, 3, 1'b0, 0, LAT_ALU,  1, 0, 1, 1};
        vt[9]  = '{1'b0, 2'b00, 0, 0, 1'b0, 0, LAT_ALU,  0, 0, 0, 0};
        vt[10] = '{1'b0, 2'b00, 0, 0, 1'b0, 0, LAT_ALU,  0, 0, 0, 0};
        vt[11] = '{1'b1, 2'b00, 0, 0, 1'b1, 7, 0,        1, 0, 0, 0};
        vt[12] = '{1'b1, 2'b01, 7, 0, 1'b0, 0, LAT_ALU,  1, 0, 1, 0};
        vt[13] = '{1'b1, 2'b00, 7, 0, 1'b0, 0, LAT_ALU,  1, 0, 0, 0};
        vt[14] = '{1'b1, 2'b00, 0, 0, 1'b1, 4, LAT_LOAD, 1, 0, 0, 0};
        vt[15] = '{1'b0, 2'b01, 4, 0, 1'b0, 0, LAT_ALU,  0, 0, 1, 0};
        rst = 1'b1;
        bus.stall_ext  = 1'b0;
        bus.flush_mask = '0;
        drive(1'b0, 2'b00, 0, 0, 1'b0, 0, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int n = 0; n < 16; n++) begin
            drive(vt[n].v, vt[n].sen, vt[n].s0, vt[n].s1, vt[n].den, vt[n].d, vt[n].lat, 1'b0);
            #2;
            expect_out($sformatf("vec%0d", n), vt[n].iss, vt[n].stl, vt[n].sel0, vt[n].sel1, 0);
            step();
        end
        idle(3);
        drive(1'b1, 2'b00, 0, 0, 1'b1, 4, LAT_LOAD, 1'b0);
        #2;
        expect_out("frz ld", 1, 0, 0, 0, 0);
        step();
        bus.stall_ext = 1'b1;
        drive(1'b1, 2'b01, 4, 0, 1'b0, 0, LAT_ALU, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #2;
            expect_out($sformatf("frz hold%0d", c), 0, 0, 1, 0, 0);
            step();
        end
        bus.stall_ext = 1'b0;
        #2;
        expect_out("frz release", 0, 1, 1, 0, 0);
        step();
        #2;
        expect_out("frz issue", 1, 0, 2, 0, 0);
        step();
        idle(3);
        drive(1'b1, 2'b00, 0, 0, 1'b1, 5, LAT_LOAD, 1'b0);
        #2;
        expect_out("fl ld", 1, 0, 0, 0, 0);
        step();
        bus.flush_mask = 3'b001;
        drive(1'b1, 2'b01, 5, 0, 1'b0, 0, LAT_ALU, 1'b0);
        #2;
        expect_out("fl kill", 1, 0, 0, 0, 0);
        step();
        bus.flush_mask = '0;
        #2;
        expect_out("fl gone", 1, 0, 0, 0, 0);
        step();
        idle(3);
        drive(1'b1, 2'b00, 0, 0, 1'b1, 1, LAT_ALU, 1'b0);
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b1, 2, LAT_ALU, 1'b0);
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b0, 0, LAT_ALU, 1'b1);
        #2;
        expect_out("halt issue", 1, 0, 0, 0, 0);
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b1, 5, LAT_ALU, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #2;
            expect_out($sformatf("drain%0d", c), 0, 0, 0, 0, c == 3 ? 1 : 0);
            step();
        end
        #2;
        expect_out("halted sticky", 0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        expect_out("halted rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b1, 6, LAT_ALU, 1'b0);
        #2;
        expect_out("rst w", 1, 0, 0, 0, 0);
        step();
        drive(1'b1, 2'b00, 0, 0, 1'b0, 0, LAT_ALU, 1'b1);
        #2;
        expect_out("rst halt", 1, 0, 0, 0, 0);
        step();
        drive(1'b1, 2'b01, 6, 0, 1'b0, 0, LAT_ALU, 1'b0);
        #2;
        expect_out("rst drain", 0, 0, 2, 0, 0);
        rst = 1'b1;
        #1;
        expect_out("rst mid", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("rst run", 1, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
